// File: rtl/sv32_page_walker.sv
// Sv32 hardware page-table walker.
// Resolves one TLB miss at a time: issues up to two PTE loads through the
// page-walk load port, checks the returned PTEs, and returns either a leaf
// PPN with its flags or a page fault. Only one PTE load is ever outstanding;
// a flushed walk drains its pending load response before going idle.
module sv32_page_walker #(
    parameter int PPN_W    = 20,
    parameter bit CHECK_AD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             IN_rqValid,
    input  logic [31:0]      IN_rqAddr,
    input  logic             IN_rqIsStore,
    input  logic [PPN_W-1:0] IN_rqRootPPN,
    output logic             OUT_rqReady,

    input  logic             IN_flush,

    output logic             OUT_ldValid,
    output logic [31:0]      OUT_ldAddr,
    input  logic             IN_ldStall,
    input  logic             IN_ldResValid,
    input  logic [31:0]      IN_ldResData,

    output logic             OUT_resValid,
    output logic             OUT_resFault,
    output logic             OUT_resSuper,
    output logic [PPN_W-1:0] OUT_resPPN,
    output logic [7:0]       OUT_resFlags,
    output logic [31:0]      OUT_resVAddr
);

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        RESP,
        DRAIN
    } walkState_t;

    walkState_t state, nextState;

    // Request context captured at accept time.
    logic [31:0]      vaddr;
    logic             isStore;
    logic [PPN_W-1:0] rootPPN;
    // Next-level table pointer taken from a non-leaf level-1 PTE.
    logic [PPN_W-1:0] ptrPPN;

    // Registered result fields.
    logic             resFault;
    logic             resSuper;
    logic [PPN_W-1:0] resPPN;
    logic [7:0]       resFlags;

    // Decoded view of the PTE currently on IN_ldResData.
    logic             atL1;
    logic             pteLeaf;
    logic             pteFault;
    logic             goDeeper;
    logic             pteAccept;
    logic [PPN_W-1:0] leafPPN;

    // The RSW bits carry no meaning for the walker.
    logic unusedRsw;
    assign unusedRsw = ^IN_ldResData[9:8];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge values, independent of block order.
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Classify the returned PTE: pointer, leaf, or fault at the current level.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        atL1      = 1'b0;
        pteLeaf   = 1'b0;
        pteFault  = 1'b0;
        goDeeper  = 1'b0;
        pteAccept = 1'b0;
        leafPPN   = '0;

        atL1    = (state == L1_WAIT);
        pteLeaf = IN_ldResData[1] | IN_ldResData[3];

        // Invalid, write-only reserved encoding, or PPN beyond a 32-bit PA.
        if (!IN_ldResData[0] || (!IN_ldResData[1] && IN_ldResData[2]) ||
            (IN_ldResData[31:30] != 2'b00))
            pteFault = 1'b1;

        // A megapage must be aligned to 4 MiB.
        if (atL1 && pteLeaf && (IN_ldResData[19:10] != 10'd0))
            pteFault = 1'b1;

        // There is no level below level 0.
        if (!atL1 && !pteLeaf)
            pteFault = 1'b1;

        if (CHECK_AD && pteLeaf &&
            (!IN_ldResData[6] || (isStore && !IN_ldResData[7])))
            pteFault = 1'b1;

        goDeeper  = atL1 && !pteLeaf && !pteFault;
        pteAccept = ((state == L1_WAIT) || (state == L0_WAIT)) &&
                    IN_ldResValid && !IN_flush;

        // A megapage passes VPN0 through as the low half of the PPN.
        if (atL1) leafPPN = PPN_W'({IN_ldResData[29:20], vaddr[21:12]});
        else      leafPPN = PPN_W'(IN_ldResData[29:10]);
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        nextState    = state;
        OUT_rqReady  = 1'b0;
        OUT_ldValid  = 1'b0;
        OUT_ldAddr   = '0;
        OUT_resValid = 1'b0;

        unique case (state)
            IDLE: begin
                OUT_rqReady = !IN_flush;
                if (IN_rqValid && !IN_flush) nextState = L1_REQ;
            end
            L1_REQ: begin
                OUT_ldValid = !IN_flush;
                OUT_ldAddr  = 32'({rootPPN, vaddr[31:22], 2'b00});
                if (IN_flush)         nextState = IDLE;
                else if (!IN_ldStall) nextState = L1_WAIT;
            end
            L1_WAIT: begin
                if (IN_flush)           nextState = IN_ldResValid ? IDLE : DRAIN;
                else if (IN_ldResValid) nextState = goDeeper ? L0_REQ : RESP;
            end
            L0_REQ: begin
                OUT_ldValid = !IN_flush;
                OUT_ldAddr  = 32'({ptrPPN, vaddr[21:12], 2'b00});
                if (IN_flush)         nextState = IDLE;
                else if (!IN_ldStall) nextState = L0_WAIT;
            end
            L0_WAIT: begin
                if (IN_flush)           nextState = IN_ldResValid ? IDLE : DRAIN;
                else if (IN_ldResValid) nextState = RESP;
            end
            RESP: begin
                OUT_resValid = !IN_flush;
                nextState    = IDLE;
            end
            DRAIN: begin
                if (IN_ldResValid) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Capture request context, the level-0 pointer and the walk result.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, because the result
        // fields are visible on the outputs and must read 0 after reset.
        if (rst) begin
            vaddr    <= '0;
            isStore  <= 1'b0;
            rootPPN  <= '0;
            ptrPPN   <= '0;
            resFault <= 1'b0;
            resSuper <= 1'b0;
            resPPN   <= '0;
            resFlags <= '0;
        end else begin
            if (state == IDLE && IN_rqValid && !IN_flush) begin
                vaddr   <= IN_rqAddr;
                isStore <= IN_rqIsStore;
                rootPPN <= IN_rqRootPPN;
            end
            if (pteAccept) begin
                if (goDeeper) begin
                    ptrPPN <= PPN_W'(IN_ldResData[29:10]);
                end else begin
                    resFault <= pteFault;
                    resSuper <= atL1 && !pteFault;
                    resPPN   <= pteFault ? '0 : leafPPN;
                    resFlags <= IN_ldResData[7:0];
                end
            end
        end
    end

    assign OUT_resFault = resFault;
    assign OUT_resSuper = resSuper;
    assign OUT_resPPN   = resPPN;
    assign OUT_resFlags = resFlags;
    assign OUT_resVAddr = vaddr;

endmodule

// File: doc/sv32_page_walker.md
Name: sv32_page_walker

Overview:
- Hardware Sv32 page-table walker that resolves one TLB miss at a time.
- Issues PTE loads through the page-walk load port. The load selector gives that port priority over AGU loads.
- Consumes the load results, checks PTE permissions and alignment, and returns a translated PPN plus flags, or a page fault, to the requesting TLB.

Parameters:
- PPN_W, 20, physical page number width (physical address = PPN_W+12 = 32 bits)
- CHECK_AD, 1, 1: fault when A=0, or when a store finds D=0; 0: ignore A/D

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_rqValid  in  1  walk request
- IN_rqAddr  in  32  virtual address to translate
- IN_rqIsStore  in  1  request is for a store (A/D check)
- IN_rqRootPPN  in  PPN_W  satp.PPN captured with request
- OUT_rqReady  out  1  walker idle, request accepted this cycle if valid
- IN_flush  in  1  abort current walk (sfence/trap)
- OUT_ldValid  out  1  PTE load valid (PW_LD_UOp.valid)
- OUT_ldAddr  out  32  PTE physical address (PW_LD_UOp.addr), word aligned
- IN_ldStall  in  1  load port stalled; hold load
- IN_ldResValid  in  1  PTE load data returned
- IN_ldResData  in  32  PTE
- OUT_resValid  out  1  result pulse
- OUT_resFault  out  1  page fault
- OUT_resSuper  out  1  4 MiB megapage leaf
- OUT_resPPN  out  PPN_W  leaf PPN (megapage: {PPN1, VPN0})
- OUT_resFlags  out  8  PTE[7:0] (D A G U X W R V)
- OUT_resVAddr  out  32  echoed request address

Behaviour:
- Reset: state IDLE; OUT_rqReady=1; OUT_ldValid=0; OUT_resValid=0; other outputs 0.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DRAIN.
- IDLE: if IN_rqValid && !IN_flush, latch addr, isStore, rootPPN; go to L1_REQ. OUT_rqReady=1 only in IDLE.
- L1_REQ: OUT_ldValid=1, OUT_ldAddr={rootPPN, VA[31:22], 2'b00}.
  - Load is issued on the first cycle with !IN_ldStall; then go to L1_WAIT.
  - Address stays stable while stalled.
- L1_WAIT: on IN_ldResValid, decode the PTE:
  - V=0, or (R=0 && W=1): fault.
  - R|X leaf: fault if PTE[19:10]!=0 (misaligned megapage); else megapage result.
  - Otherwise pointer: latch PPN=PTE[29:10]; go to L0_REQ with OUT_ldAddr={PPN, VA[21:12], 2'b00}.
- L0_WAIT: V/RW rule as above. Non-leaf at level 0 faults. Leaf gives PPN=PTE[29:10].
- CHECK_AD=1: leaf with A=0, or IsStore with D=0, faults.
- PTE[31:30] (PPN1 high bits) nonzero also faults, since the PA is limited to 32 bits.
- RESP: OUT_resValid=1 for exactly one cycle with registered fields; then IDLE. On fault, PPN=0 and flags carry the faulting PTE[7:0].
- Result latency, zero stall, two-level walk: load issued 1 cycle after accept; result 1 cycle after the final IN_ldResValid.
- Only one PTE load is ever outstanding. IN_ldResValid outside the WAIT/DRAIN states is ignored.
- IN_flush:
  - In L1_REQ/L0_REQ: OUT_ldValid drops the same cycle (combinational mask); go to IDLE.
  - In a WAIT state: go to DRAIN, which discards the next IN_ldResValid and then goes to IDLE. DRAIN with a same-cycle IN_ldResValid goes directly to IDLE.
  - In RESP: OUT_resValid suppressed.
  - In IDLE: the request is not accepted.
- Flush and IN_ldResValid in the same WAIT cycle: the result is discarded and the state goes to IDLE.
- rst mid-walk: immediate return to IDLE; the outstanding load response is ignored.

Test Plan:
1. Request VA=0x0040_3123, root=0x80000. Expect L1 load at 0x8000_0004. Return 0x2000_0401 (pointer PPN 0x80001). Expect L0 load at 0x8000_100C. Return 0x2000_08CF (leaf RWXV, A, D). Expect resValid, PPN=0x80002, Fault=0, Super=0, Flags=0xCF.
2. Megapage: L1 returns 0x2000_00CF (PPN0=0). Expect Super=1, PPN={0x200, VA[21:12]}. With L1 PTE 0x2000_04CF (PPN0 nonzero), expect Fault=1.
3. Faults: L1 PTE=0x0 gives Fault. PTE W-only (0x05) gives Fault. Store with leaf 0x4F (D=0) and CHECK_AD=1 gives Fault; the same case with CHECK_AD=0 gives Fault=0.
4. IN_ldStall held 5 cycles in L1_REQ: OUT_ldValid and OUT_ldAddr stable throughout, exactly one load issued, result delayed by 5 cycles.
5. Flush in L1_WAIT, then the stale PTE arrives 3 cycles later: no resValid, OUT_rqReady returns after the drain, and the next request walks correctly. Flush in L0_REQ: OUT_ldValid=0 the same cycle.
6. rst asserted in L0_WAIT: all outputs at reset values the next cycle. A late IN_ldResValid produces no result.
